gen_sync_fifo: RTL
==================

Name: gen_sync_fifo

Overview:
- Parameterised synchronous FIFO with valid/ready handshake on both ends; the buffered counterpart to the plain register primitive.
- Decouples a producer and a consumer in the same clock domain: pipeline decoupling, testbench stimulus/monitor queues, commit buffers.
- First-word fall-through read side.
- One clock; storage is a flop array plus read/write pointers and an occupancy counter.

Parameters:
- DW, 32, data width in bits.
- AW, 2, pointer width; DEPTH = 2**AW entries; AW >= 1.
- rstValue, {DW{1'b0}}, value driven on deq_bits while the FIFO is empty.

Ports:
- CLK  input  1  clock; all state updates on its rising edge.
- RST  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
- flush  input  1  synchronous clear of contents.
- enq_valid  input  1  producer has data.
- enq_ready  output  1  FIFO can accept data.
- enq_bits  input  DW  producer data.
- deq_valid  output  1  FIFO holds data.
- deq_ready  input  1  consumer accepts data.
- deq_bits  output  DW  head entry.
- count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset and handshake definitions:
  - RST high at a CLK edge: wr_ptr=0, rd_ptr=0, count=0. The storage array is not reset.
  - While RST is high, enq_ready=0 and deq_valid=0 combinationally, so no handshakes occur.
  - Output values after reset: enq_ready=1, deq_valid=0, deq_bits=rstValue, count=0.
  - enq fire = enq_valid & enq_ready; deq fire = deq_valid & deq_ready.
- Output derivation:
  - enq_ready = (count != DEPTH) & ~RST. It is a function of registered state only, with no combinational path from deq_ready.
  - deq_valid = (count != 0) & ~RST.
  - deq_bits = mem[rd_ptr] when count != 0, else rstValue.
- Write and read:
  - On enq fire: mem[wr_ptr] <= enq_bits; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
  - On deq fire: rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- Count update:
  - enq fire only: +1.
  - deq fire only: -1.
  - Both, or neither: unchanged.
- Latency: data enqueued at edge N is visible on deq_bits with deq_valid=1 after edge N. There is no same-cycle bypass when empty.
- Full boundary: when count==DEPTH, enq_ready=0 even if deq fires that cycle. The freed slot is offered on the following cycle.
- Empty boundary: when count==0, deq_ready is ignored, and an enq that cycle does not appear on deq_bits until the next cycle.
- Simultaneous enq and deq with 0<count<DEPTH: both pointers advance; order is preserved; count holds.
- Flush:
  - When flush is high at an edge, wr_ptr, rd_ptr and count are cleared.
  - Flush dominates any enq/deq fire in the same cycle; that enq is dropped.
  - Handshake outputs are not gated during the flush cycle.
- Priority: RST > flush > normal operation.
- Reset mid-operation: any in-flight data is discarded, and the next cycle behaves as freshly reset.
- Wrap-around: pointers are AW bits and wrap naturally; full/empty are determined by count, never by pointer comparison.

Test Plan (DW=32, AW=2, DEPTH=4, rstValue=0):
- Reset hold: hold RST=1 for 3 cycles while driving enq_valid=1, enq_bits=0xDEAD -> enq_ready=0, deq_valid=0; after release count=0, deq_bits=0x0.
- Fill: enq 0x11,0x22,0x33,0x44 on consecutive cycles with deq_ready=0 -> count steps 1,2,3,4; enq_ready=0 after the 4th edge; a 5th enq of 0x55 is not accepted; deq_bits=0x11.
- Full with simultaneous deq: from full, set deq_ready=1 and enq_valid=1 with 0x55 -> cycle 1: only the deq fires, count=3; next cycle 0x55 is accepted; dequeue order is 0x11,0x22,0x33,0x44,0x55.
- Streaming wrap: keep count=2, then enq and deq every cycle for 10 cycles with incrementing data 0x100.. -> count stays 2; output sequence is the input delayed by two transfers; pointers wrap at least twice with no loss.
- Empty enq latency: from empty, enq 0xAB with deq_ready=1 -> same cycle deq_valid=0; next cycle deq_valid=1, deq_bits=0xAB, deq fires, count returns to 0.
- Flush: with count=3, assert flush together with enq_valid=1 (0xCC) and deq_ready=1 -> next cycle count=0, deq_valid=0, deq_bits=0x0; 0xCC is never dequeued.

Source files
------------

// File: rtl/gen_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gen_sync_fifo : single-clock valid/ready FIFO, first-word fall-through    |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module gen_sync_fifo #(
  parameter int            DW       = 32,
  parameter int            AW       = 2,
  parameter logic [DW-1:0] rstValue = {DW{1'b0}}
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          flush,
  input  logic          enq_valid,
  output logic          enq_ready,
  input  logic [DW-1:0] enq_bits,
  output logic          deq_valid,
  input  logic          deq_ready,
  output logic [DW-1:0] deq_bits,
  output logic [AW:0]   count
);

  localparam int        DEPTH   = 1 << AW;
  localparam logic [AW:0] C_FULL  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] C_EMPTY = '0;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          w_enq_fire;
  logic          w_deq_fire;

  // Readiness depends only on registered occupancy, so deq_ready never
  // reaches enq_ready combinationally.
  assign enq_ready  = (count_q != C_FULL) & ~RST;
  assign deq_valid  = (count_q != C_EMPTY) & ~RST;
  assign deq_bits   = (count_q != C_EMPTY) ? mem_q[rd_ptr_q] : rstValue;
  assign count      = count_q;
  assign w_enq_fire = enq_valid & enq_ready;
  assign w_deq_fire = deq_valid & deq_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_enq_fire) begin
        mem_d[wr_ptr_q] = enq_bits;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (w_deq_fire) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({w_enq_fire, w_deq_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale entries are hidden by count.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire
